// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an asynchronous serial transmitter.
// Frame on uart_txd: start bit (0), PAYLOAD_BITS data bits LSB first,
// optional even parity bit, STOP_BITS stop bits (1). Line idles high.
// Build option: define UART_TX_PARITY_EN to insert the even parity bit
// between the last data bit and the first stop bit.
//
// Input handshake: a byte is accepted on any rising clk edge where
// tx_valid && tx_ready. tx_ready is simply !full and does not depend on
// tx_valid. A byte offered while full is not accepted and the FIFO is left
// untouched; the sender may keep tx_valid high until tx_ready returns.
module uart_tx_fifo #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          uart_tx_en,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CPB_LAST   = CW'(CPB - 1);
  localparam logic [2:0]    DATA_LAST  = 3'(PAYLOAD_BITS - 1);
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_COUNT = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, push, pop;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_idx;
  logic          bit_end, can_start;
  logic [7:0]    shift, shift_next;
  logic          txd_next;
`ifdef UART_TX_PARITY_EN
  logic          parity, parity_next;
`endif

  assign full         = (fifo_count == FULL_COUNT);
  assign tx_ready     = !full;
  assign push         = tx_valid && tx_ready;
  assign can_start    = uart_tx_en && (fifo_count != '0);
  assign bit_end      = (state != S_IDLE) && (cyc_cnt == CPB_LAST);
  assign uart_tx_busy = (state != S_IDLE);

  // FIFO storage: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // FSM next-state: advance on bit boundaries, chain frames from STOP.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (can_start) state_next = S_START;
      S_START:  if (bit_end) state_next = S_DATA;
      S_DATA:   if (bit_end && bit_idx == DATA_LAST)
`ifdef UART_TX_PARITY_EN
                  state_next = S_PARITY;
      S_PARITY: if (bit_end) state_next = S_STOP;
`else
                  state_next = S_STOP;
`endif
      S_STOP:   if (bit_end && bit_idx == STOP_LAST)
                  state_next = can_start ? S_START : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // FSM outputs: pop/load, next line level and shift register updates.
  always_comb begin
    pop        = 1'b0;
    txd_next   = uart_txd;
    shift_next = shift;
`ifdef UART_TX_PARITY_EN
    parity_next = parity;
`endif
    case (state)
      S_IDLE: begin
        if (can_start) begin
          pop        = 1'b1;
          txd_next   = 1'b0;
          shift_next = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
          parity_next = 1'b0;
`endif
        end
      end
      S_START, S_DATA: begin
        if (bit_end) begin
          if (state == S_DATA && bit_idx == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            txd_next = parity;
`else
            txd_next = 1'b1;
`endif
          end else begin
            // Next data bit goes out; parity tracks only bits actually sent.
            txd_next   = shift[0];
            shift_next = {1'b0, shift[7:1]};
`ifdef UART_TX_PARITY_EN
            parity_next = parity ^ shift[0];
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) txd_next = 1'b1;
`endif
      S_STOP: begin
        txd_next = 1'b1;
        if (bit_end && bit_idx == STOP_LAST && can_start) begin
          pop        = 1'b1;
          txd_next   = 1'b0;
          shift_next = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
          parity_next = 1'b0;
`endif
        end
      end
      default: txd_next = 1'b1;
    endcase
  end

  // Datapath registers: line, shifter, bit-period counter and bit index.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_txd <= 1'b1;
      shift    <= '0;
      cyc_cnt  <= '0;
      bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      uart_txd <= txd_next;
      shift    <= shift_next;
`ifdef UART_TX_PARITY_EN
      parity   <= parity_next;
`endif
      if (state == S_IDLE || bit_end) cyc_cnt <= '0;
      else                            cyc_cnt <= cyc_cnt + 1'b1;
      // Index restarts on every state change so DATA and STOP share it.
      if (state_next != state) bit_idx <= '0;
      else if (bit_end)        bit_idx <= bit_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small bit period (50 kHz clock,
// 9600 bit/s -> 5 clocks per bit after truncation) and a 4-entry FIFO.
module tb_uart_tx_fifo;

  localparam int CPB = 5;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 1 + 8 + P + 1;

  logic       clk;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_tx_en;
  logic       uart_txd;
  logic       uart_tx_busy;
  logic [2:0] fifo_count;

  int checks;
  int failures;

  logic [11:0] rx_bits;
  logic        rx_stable;
  int          rx_waited;

  uart_tx_fifo #(
    .BIT_RATE(9600),
    .CLK_HZ(50_000),
    .PAYLOAD_BITS(8),
    .STOP_BITS(1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .uart_tx_en(uart_tx_en),
    .uart_txd(uart_txd),
    .uart_tx_busy(uart_tx_busy),
    .fifo_count(fifo_count)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Expected line levels of one frame, index 0 = start bit.
  function automatic logic [11:0] exp_frame(input logic [7:0] b);
    logic [11:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i + 1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9]  = ^b;
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  // Driver: offer one byte for one cycle; call and return at a negedge.
  task automatic push(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Receiver model: waits (bounded) for a start bit, samples every cycle of
  // the frame, returns first-cycle level per bit and whether each bit held
  // for the whole period; ends on the first cycle after the frame.
  task automatic rx_frame(output logic [11:0] bits, output logic stable, output int waited);
    bits   = '0;
    stable = 1'b1;
    waited = 0;
    while (uart_txd !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (uart_txd !== 1'b0) begin
      waited = -1;
      return;
    end
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (c == 0) bits[k] = uart_txd;
        else if (uart_txd !== bits[k]) stable = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", uart_txd); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
    checks++; if (uart_tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", uart_tx_busy); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    uart_tx_en = 1'b1;
    push(8'h41);
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_count_e0: got %0d expected 1", fifo_count); end
    checks++; if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) begin failures++; $display("FAIL single_idle_e0: got txd=%b busy=%b expected 1 0", uart_txd, uart_tx_busy); end
    @(negedge clk);
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL single_count_e1: got %0d expected 0", fifo_count); end
    checks++; if (uart_txd !== 1'b0 || uart_tx_busy !== 1'b1) begin failures++; $display("FAIL single_start_e1: got txd=%b busy=%b expected 0 1", uart_txd, uart_tx_busy); end
    rx_frame(rx_bits, rx_stable, rx_waited);
    checks++; if (rx_waited !== 0) begin failures++; $display("FAIL single_latency: got %0d expected 0", rx_waited); end
    checks++; if (rx_bits !== exp_frame(8'h41)) begin failures++; $display("FAIL single_bits: got %h expected %h", rx_bits, exp_frame(8'h41)); end
`ifndef UART_TX_PARITY_EN
    checks++; if (rx_bits !== 12'b0010_1000_0010) begin failures++; $display("FAIL single_bits_0x41: got %b expected 001010000010", rx_bits); end
`endif
    checks++; if (rx_stable !== 1'b1) begin failures++; $display("FAIL single_bit_period: got %b expected 1", rx_stable); end
    checks++; if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) begin failures++; $display("FAIL single_end: got busy=%b txd=%b expected 0 1", uart_tx_busy, uart_txd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [3];
    logic [7:0] c;
    string line;
    string got;
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A;
    line = "";
    got  = "";
    uart_tx_en = 1'b0;
    for (int i = 0; i < 3; i++) push(msg[i]);
    checks++; if (fifo_count !== 3'd3 || uart_tx_busy !== 1'b0) begin failures++; $display("FAIL b2b_queued: got count=%0d busy=%b expected 3 0", fifo_count, uart_tx_busy); end
    uart_tx_en = 1'b1;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd2 || uart_txd !== 1'b0) begin failures++; $display("FAIL b2b_first_pop: got count=%0d txd=%b expected 2 0", fifo_count, uart_txd); end
    for (int i = 0; i < 3; i++) begin
      rx_frame(rx_bits, rx_stable, rx_waited);
      checks++; if (rx_waited !== 0) begin failures++; $display("FAIL b2b_gap%0d: got %0d expected 0", i, rx_waited); end
      checks++; if (rx_bits !== exp_frame(msg[i]) || rx_stable !== 1'b1) begin failures++; $display("FAIL b2b_frame%0d: got %h stable=%b expected %h 1", i, rx_bits, rx_stable, exp_frame(msg[i])); end
      c = rx_bits[8:1];
      if (c == 8'h0A) begin
        $display("TB_UART :%s", line);
        got  = line;
        line = "";
      end else begin
        line = $sformatf("%s%c", line, c);
      end
    end
    checks++; if (got != "Hi") begin failures++; $display("FAIL b2b_text: got '%s' expected 'Hi'", got); end
    checks++; if (uart_tx_busy !== 1'b0) begin failures++; $display("FAIL b2b_end_busy: got %b expected 0", uart_tx_busy); end
  endtask

  task automatic test_fifo_full();
    int bad;
    uart_tx_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h11 * (i + 1)));
      if (i == 2) begin
        checks++; if (tx_ready !== 1'b1 || fifo_count !== 3'd3) begin failures++; $display("FAIL full_three: got ready=%b count=%0d expected 1 3", tx_ready, fifo_count); end
      end
    end
    checks++; if (tx_ready !== 1'b0 || fifo_count !== 3'd4) begin failures++; $display("FAIL full_four: got ready=%b count=%0d expected 0 4", tx_ready, fifo_count); end
    push(8'h55);
    checks++; if (tx_ready !== 1'b0 || fifo_count !== 3'd4) begin failures++; $display("FAIL full_drop: got ready=%b count=%0d expected 0 4", tx_ready, fifo_count); end
    uart_tx_en = 1'b1;
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1 || fifo_count !== 3'd3 || uart_txd !== 1'b0) begin failures++; $display("FAIL full_reready: got ready=%b count=%0d txd=%b expected 1 3 0", tx_ready, fifo_count, uart_txd); end
    for (int i = 0; i < 4; i++) begin
      rx_frame(rx_bits, rx_stable, rx_waited);
      checks++; if (rx_waited !== 0 || rx_stable !== 1'b1 || rx_bits !== exp_frame(8'(8'h11 * (i + 1)))) begin failures++; $display("FAIL full_frame%0d: got %h wait=%0d stable=%b expected %h 0 1", i, rx_bits, rx_waited, rx_stable, exp_frame(8'(8'h11 * (i + 1)))); end
    end
    checks++; if (fifo_count !== 3'd0 || uart_tx_busy !== 1'b0) begin failures++; $display("FAIL full_drained: got count=%0d busy=%b expected 0 0", fifo_count, uart_tx_busy); end
    bad = 0;
    repeat (3 * NB * CPB) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL full_no_fifth: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_push_pop();
    uart_tx_en = 1'b0;
    push(8'h5A);
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL pp_setup: got %0d expected 1", fifo_count); end
    tx_data    = 8'hA5;
    tx_valid   = 1'b1;
    uart_tx_en = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1 || uart_txd !== 1'b0) begin failures++; $display("FAIL pp_count: got count=%0d txd=%b expected 1 0", fifo_count, uart_txd); end
    rx_frame(rx_bits, rx_stable, rx_waited);
    checks++; if (rx_waited !== 0 || rx_bits !== exp_frame(8'h5A)) begin failures++; $display("FAIL pp_frame0: got %h wait=%0d expected %h 0", rx_bits, rx_waited, exp_frame(8'h5A)); end
    rx_frame(rx_bits, rx_stable, rx_waited);
    checks++; if (rx_waited !== 0 || rx_bits !== exp_frame(8'hA5)) begin failures++; $display("FAIL pp_frame1: got %h wait=%0d expected %h 0", rx_bits, rx_waited, exp_frame(8'hA5)); end
  endtask

  task automatic test_en_drop();
    int bad;
    uart_tx_en = 1'b1;
    push(8'h3C);
    @(negedge clk);
    fork
      rx_frame(rx_bits, rx_stable, rx_waited);
      begin
        repeat (3 * CPB) @(negedge clk);
        uart_tx_en = 1'b0;
        push(8'hC3);
      end
    join
    checks++; if (rx_waited !== 0 || rx_stable !== 1'b1 || rx_bits !== exp_frame(8'h3C)) begin failures++; $display("FAIL endrop_frame: got %h wait=%0d stable=%b expected %h 0 1", rx_bits, rx_waited, rx_stable, exp_frame(8'h3C)); end
    bad = 0;
    repeat (2 * NB * CPB) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0 || fifo_count !== 3'd1) begin failures++; $display("FAIL endrop_hold: got active=%0d count=%0d expected 0 1", bad, fifo_count); end
  endtask

  task automatic test_reset_mid();
    int bad;
    // FIFO holds 0xC3 from the previous scenario; add one more byte.
    push(8'h00);
    uart_tx_en = 1'b1;
    @(negedge clk);
    // Cycle 17 of the frame is inside data bit 2 of 0xC3, which is 0.
    repeat (17) @(negedge clk);
    checks++; if (uart_txd !== 1'b0 || uart_tx_busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre: got txd=%b busy=%b expected 0 1", uart_txd, uart_tx_busy); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (uart_txd !== 1'b1 || fifo_count !== 3'd0 || uart_tx_busy !== 1'b0 || tx_ready !== 1'b1) begin failures++; $display("FAIL rstmid_async: got txd=%b count=%0d busy=%b ready=%b expected 1 0 0 1", uart_txd, fifo_count, uart_tx_busy, tx_ready); end
    @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    repeat (3 * NB * CPB) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad); end
    push(8'h96);
    @(negedge clk);
    rx_frame(rx_bits, rx_stable, rx_waited);
    checks++; if (rx_waited !== 0 || rx_stable !== 1'b1 || rx_bits !== exp_frame(8'h96)) begin failures++; $display("FAIL rstmid_after: got %h wait=%0d stable=%b expected %h 0 1", rx_bits, rx_waited, rx_stable, exp_frame(8'h96)); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    uart_tx_en = 1'b1;
    push(8'h03);
    @(negedge clk);
    rx_frame(rx_bits, rx_stable, rx_waited);
    checks++; if (rx_bits[9] !== 1'b0 || rx_bits[10] !== 1'b1) begin failures++; $display("FAIL parity_03: got par=%b stop=%b expected 0 1", rx_bits[9], rx_bits[10]); end
    checks++; if (uart_tx_busy !== 1'b0 || rx_stable !== 1'b1) begin failures++; $display("FAIL parity_len_03: got busy=%b stable=%b expected 0 1", uart_tx_busy, rx_stable); end
    push(8'h07);
    @(negedge clk);
    rx_frame(rx_bits, rx_stable, rx_waited);
    checks++; if (rx_bits[9] !== 1'b1 || rx_bits[10] !== 1'b1) begin failures++; $display("FAIL parity_07: got par=%b stop=%b expected 1 1", rx_bits[9], rx_bits[10]); end
    checks++; if (uart_tx_busy !== 1'b0 || rx_stable !== 1'b1) begin failures++; $display("FAIL parity_len_07: got busy=%b stable=%b expected 0 1", uart_tx_busy, rx_stable); end
  endtask
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    resetn     = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    uart_tx_en = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_push_pop();
    test_en_drop();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
